// File: rtl/rx_serial_fifo_if.sv
// Bus between the oversampling serial receiver and the word consumer.
// The master modport is the receiver side, the slave modport is the consumer side.
interface rx_serial_fifo_if #(
    parameter int N_BITS     = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                        rxd;
    logic                        pop;
    logic                        clear_errors;
    logic                        valid;
    logic [N_BITS-1:0]           data;
    logic                        parity_error;
    logic                        framing_error;
    logic                        overrun;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [2:0]                  db_estado;

    modport master (
        input  rxd,
        input  pop,
        input  clear_errors,
        output valid,
        output data,
        output parity_error,
        output framing_error,
        output overrun,
        output fifo_count,
        output db_estado
    );

    modport slave (
        output rxd,
        output pop,
        output clear_errors,
        input  valid,
        input  data,
        input  parity_error,
        input  framing_error,
        input  overrun,
        input  fifo_count,
        input  db_estado
    );
endinterface

// File: rtl/rx_serial_fifo.sv
// Oversampling UART receiver with majority vote, parity/framing checks and a first-word-fall-through FIFO.
// Optional macro RX_SERIAL_BREAK_DETECT_EN adds a break_detect pulse and drops all-zero break frames.
module rx_serial_fifo #(
    parameter int BAUD_RATE   = 9600,
    parameter int CLOCK_HZ    = 50_000_000,
    parameter int N_BITS      = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic clock,
    input  logic reset,
`ifdef RX_SERIAL_BREAK_DETECT_EN
    output logic break_detect,
`endif
    rx_serial_fifo_if.master bus
);

    localparam int DIV_RAW = CLOCK_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = $clog2(DIV + 1);
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(N_BITS);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int EW      = N_BITS + 2;

    localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
    localparam logic [SW-1:0] SAMP_A     = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_B     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_C     = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SAMP_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(N_BITS - 1);
    localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b010,
        PARITY = 3'b011,
        STOP   = 3'b100,
        PUSH   = 3'b101
    } state_t;

    state_t            state;
    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    logic [DW-1:0]     div_cnt;
    logic [SW-1:0]     sample_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              stop_cnt;
    logic              samp_a;
    logic              samp_b;
    logic [N_BITS-1:0] shift_reg;
    logic              frame_pe;
    logic              frame_fe;
    logic              wait_high;
`ifdef RX_SERIAL_BREAK_DETECT_EN
    logic              par_bit;
`endif

    logic              tick;
    logic              at_maj;
    logic              at_end;
    logic              maj;
    logic              fe_next;

    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              overrun_r;
    logic              push;
    logic              do_pop;
    logic              full;
    logic              do_write;
    logic [EW-1:0]     head;

    assign tick    = (state != IDLE) && (div_cnt == DIV_LAST);
    assign at_maj  = tick && (sample_cnt == SAMP_C);
    assign at_end  = tick && (sample_cnt == SAMP_LAST);
    assign maj     = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
    assign fe_next = frame_fe | ~maj;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bus.rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Held at zero in IDLE so every frame starts counting from the START entry.
    always_ff @(posedge clock) begin
        if (reset || state == IDLE) begin
            div_cnt    <= '0;
            sample_cnt <= '0;
        end else if (tick) begin
            div_cnt    <= '0;
            sample_cnt <= at_end ? '0 : sample_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            shift_reg <= '0;
            frame_pe  <= 1'b0;
            frame_fe  <= 1'b0;
            wait_high <= 1'b0;
`ifdef RX_SERIAL_BREAK_DETECT_EN
            par_bit      <= 1'b0;
            break_detect <= 1'b0;
`endif
        end else begin
`ifdef RX_SERIAL_BREAK_DETECT_EN
            break_detect <= 1'b0;
`endif
            if (tick && sample_cnt == SAMP_A) samp_a <= rx_sync;
            if (tick && sample_cnt == SAMP_B) samp_b <= rx_sync;

            unique case (state)
                IDLE: begin
                    // After a low stop bit the line must return high before a new start is armed.
                    if (wait_high) begin
                        if (rx_sync) wait_high <= 1'b0;
                    end else if (rx_prev && !rx_sync) begin
                        state    <= START;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        frame_pe <= 1'b0;
                        frame_fe <= 1'b0;
`ifdef RX_SERIAL_BREAK_DETECT_EN
                        par_bit  <= 1'b0;
`endif
                    end
                end

                START: begin
                    if (at_maj && maj) begin
                        state <= IDLE;
                    end else if (at_end) begin
                        state <= DATA;
                    end
                end

                DATA: begin
                    if (at_maj) shift_reg <= {maj, shift_reg[N_BITS-1:1]};
                    if (at_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (at_maj) begin
                        frame_pe <= (PARITY_MODE == 1) ? ~(^shift_reg ^ maj) : (^shift_reg ^ maj);
`ifdef RX_SERIAL_BREAK_DETECT_EN
                        par_bit  <= maj;
`endif
                    end
                    if (at_end) state <= STOP;
                end

                // The last stop bit is left at its vote point so a back-to-back start edge is not missed.
                STOP: begin
                    if (at_maj) begin
                        frame_fe <= fe_next;
                        if (stop_cnt == STOP_LAST) begin
`ifdef RX_SERIAL_BREAK_DETECT_EN
                            if (shift_reg == '0 && !par_bit && fe_next) begin
                                break_detect <= 1'b1;
                                wait_high    <= 1'b1;
                                state        <= IDLE;
                            end else begin
                                state <= PUSH;
                            end
`else
                            state <= PUSH;
`endif
                        end
                    end else if (at_end) begin
                        stop_cnt <= 1'b1;
                    end
                end

                PUSH: begin
                    state     <= IDLE;
                    wait_high <= frame_fe;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign push     = (state == PUSH);
    assign do_pop   = bus.pop && (count != '0);
    assign full     = (count == FULL_COUNT);
    assign do_write = push && (!full || do_pop);

    // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_r <= 1'b0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= {frame_fe, frame_pe, shift_reg};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;

            if (do_write && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_write && do_pop) begin
                count <= count - 1'b1;
            end

            if (push && full && !do_pop) begin
                overrun_r <= 1'b1;
            end else if (bus.clear_errors) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign head              = mem[rd_ptr];
    assign bus.valid         = (count != '0);
    assign bus.data          = bus.valid ? head[N_BITS-1:0] : '0;
    assign bus.parity_error  = bus.valid & head[N_BITS];
    assign bus.framing_error = bus.valid & head[N_BITS+1];
    assign bus.overrun       = overrun_r;
    assign bus.fifo_count    = count;
    assign bus.db_estado     = state;

endmodule
